dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single DDR memory-controller user port between two requesters: the sample write path (packer output) and the host readback engine (read requests).
- Write traffic has priority so capture never stalls. A streak limit bounds read starvation.
- Sits between dram_packer/readback logic and the memory-controller app interface. It sequences the command and write-data channels and returns read data.

Parameters:
- MEM_IF_WIDTH, 128, data width of write/read payload and app data buses.
- ADX_WIDTH, 27, address width.
- MAX_WR_STREAK, 8, max consecutive write grants while a read is pending before one read is forced.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- wr_req  in  1  write accept from packer; valid only while wr_allowed=1
- wr_data  in  MEM_IF_WIDTH  write payload, sampled when wr_req&wr_allowed
- wr_adx  in  ADX_WIDTH  write address, sampled with wr_data
- wr_allowed  out  1  write holding register empty; packer may issue
- rd_req  in  1  read request level; held with rd_adx stable until rd_valid
- rd_adx  in  ADX_WIDTH  read address
- rd_data  out  MEM_IF_WIDTH  read result, valid with rd_valid
- rd_valid  out  1  one-cycle read-return strobe
- app_en  out  1  controller command valid
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_addr  out  ADX_WIDTH  command address
- app_rdy  in  1  command accepted when app_en&app_rdy
- app_wdf_data  out  MEM_IF_WIDTH  write data
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  equals app_wdf_wren (single-beat bursts)
- app_wdf_rdy  in  1  write data accepted when app_wdf_wren&app_wdf_rdy
- app_rd_data  in  MEM_IF_WIDTH  controller read data
- app_rd_data_valid  in  1  controller read data strobe

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; hold_valid=0; streak=0.
  - All outputs 0 except wr_allowed: wr_allowed=1 one cycle after deassertion (registered from ~hold_valid).
  - An in-flight command or read is abandoned. A late app_rd_data_valid after reset is ignored (no rd_valid).
- Write holding register:
  - wr_allowed is registered, equal to ~hold_valid.
  - On wr_req&wr_allowed: capture wr_data/wr_adx and set hold_valid. wr_allowed falls next cycle.
  - wr_req while wr_allowed=0 is ignored (no capture, no error).
- FSM states IDLE, WR, RD_CMD, RD_WAIT.
- IDLE:
  - If hold_valid and (!rd_req or streak<MAX_WR_STREAK): go to WR.
  - Else if rd_req: latch rd_adx and go to RD_CMD.
  - Else stay in IDLE.
  - A decision takes one cycle; no outputs are driven in IDLE.
- WR:
  - Drive app_en=1 (cmd 000, addr=held address) and app_wdf_wren=app_wdf_end=1 with held data.
  - Track two sticky flags, cmd_done and data_done. Each channel deasserts its valid after its own handshake, independently and in either order.
  - When both are done (the same cycle is allowed): clear hold_valid, go to IDLE.
  - streak increments (saturating) if rd_req was high at the grant, else resets to 0.
- RD_CMD:
  - Drive app_en=1, cmd 001, addr=latched rd address.
  - On app_rdy go to RD_WAIT; streak resets to 0.
  - Writes may still be captured into the holding register meanwhile.
- RD_WAIT:
  - On app_rd_data_valid, register rd_data and pulse rd_valid the next cycle, then go to IDLE.
  - Exactly one read is outstanding at a time; no timeout.
- Latency:
  - wr_req to app_en: 2 cycles minimum (capture, IDLE decision).
  - app_rd_data_valid to rd_valid: 1 cycle.
- Simultaneous events:
  - wr_req and rd_req in the same cycle: write is captured and wins the next decision unless streak≥MAX_WR_STREAK.
  - hold_valid clears and wr_req arrives in the same cycle: not possible, since wr_allowed is still 0 that cycle; the next capture is one cycle later.
- Outputs app_addr/app_cmd/app_wdf_data are 0 when their valid is low.

Test Plan:
- Reset then single write, app_rdy=app_wdf_rdy=1 -> app_en/app_wdf_wren high for exactly 1 cycle, cmd 000, addr/data match wr_adx=0x10/wr_data=0xA5..A5; wr_allowed returns to 1 the cycle after.
- Write with app_rdy held low 3 cycles, app_wdf_rdy high -> app_wdf_wren drops after 1 cycle, app_en held 4 cycles; hold released only after app_rdy.
- Read rd_adx=0x40, app_rd_data_valid 5 cycles after command with data 0x1234 -> single rd_valid pulse, rd_data=0x1234, app_cmd=001, addr 0x40.
- Continuous writes with rd_req held, MAX_WR_STREAK=8 -> exactly 8 write commands, then the read command, then writes resume; read is never starved.
- wr_req pulsed while wr_allowed=0 -> no extra app_en; write count equals accepted count.
- resetn asserted during RD_WAIT, then app_rd_data_valid arrives after release -> outputs 0 immediately on reset; no rd_valid; FSM in IDLE.

Source files
------------

// File: rtl/dram_arbiter.sv
// Shares the DDR controller app port between the sample write path and host readback.
// Writes have priority; a streak limit forces a pending read through after MAX_WR_STREAK writes.
module dram_arbiter #(
  parameter int MEM_IF_WIDTH  = 128,
  parameter int ADX_WIDTH     = 27,
  parameter int MAX_WR_STREAK = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_req,
  input  logic [MEM_IF_WIDTH-1:0] wr_data,
  input  logic [ADX_WIDTH-1:0]    wr_adx,
  output logic                    wr_allowed,
  input  logic                    rd_req,
  input  logic [ADX_WIDTH-1:0]    rd_adx,
  output logic [MEM_IF_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADX_WIDTH-1:0]    app_addr,
  input  logic                    app_rdy,
  output logic [MEM_IF_WIDTH-1:0] app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy,
  input  logic [MEM_IF_WIDTH-1:0] app_rd_data,
  input  logic                    app_rd_data_valid
);
  localparam int SW = $clog2(MAX_WR_STREAK + 1);

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_WAIT} state_t;

  state_t                  state;
  logic                    hold_valid;
  logic [MEM_IF_WIDTH-1:0] hold_data;
  logic [ADX_WIDTH-1:0]    hold_adx;
  logic [SW-1:0]           streak;
  logic                    cmd_done, data_done;
  logic                    wr_take, streak_ok, cmd_ok, data_ok, wr_done, hold_next;

  always_comb begin
    wr_take   = wr_req & wr_allowed;
    streak_ok = (streak < SW'(MAX_WR_STREAK));
    cmd_ok    = cmd_done | (app_en & app_rdy);
    data_ok   = data_done | (app_wdf_wren & app_wdf_rdy);
    wr_done   = (state == WR) & cmd_ok & data_ok;
    hold_next = wr_take | (hold_valid & ~wr_done);
  end

  // wr_allowed tracks the next-cycle occupancy so a second write can never slip in
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_adx   <= '0;
      wr_allowed <= 1'b0;
    end else begin
      hold_valid <= hold_next;
      wr_allowed <= ~hold_next;
      if (wr_take) begin
        hold_data <= wr_data;
        hold_adx  <= wr_adx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      streak       <= '0;
      cmd_done     <= 1'b0;
      data_done    <= 1'b0;
      app_en       <= 1'b0;
      app_cmd      <= 3'b000;
      app_addr     <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      app_wdf_data <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hold_valid && (!rd_req || streak_ok)) begin
            state        <= WR;
            app_en       <= 1'b1;
            app_cmd      <= 3'b000;
            app_addr     <= hold_adx;
            app_wdf_wren <= 1'b1;
            app_wdf_end  <= 1'b1;
            app_wdf_data <= hold_data;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
            streak       <= rd_req ? streak + 1'b1 : '0;
          // a write landing in the holding register this cycle still wins the next decision
          end else if (rd_req && !(wr_take && streak_ok)) begin
            state    <= RD_CMD;
            app_en   <= 1'b1;
            app_cmd  <= 3'b001;
            app_addr <= rd_adx;
          end
        end
        WR: begin
          if (app_en && app_rdy) begin
            app_en   <= 1'b0;
            app_addr <= '0;
            cmd_done <= 1'b1;
          end
          if (app_wdf_wren && app_wdf_rdy) begin
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            data_done    <= 1'b1;
          end
          if (wr_done) state <= IDLE;
        end
        RD_CMD: begin
          if (app_rdy) begin
            app_en   <= 1'b0;
            app_cmd  <= 3'b000;
            app_addr <= '0;
            streak   <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // stay here through the rd_valid cycle so a still-high rd_req is not re-issued
          if (rd_valid) state <= IDLE;
          else if (app_rd_data_valid) begin
            rd_data  <= app_rd_data;
            rd_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (pending-write queue, outstanding-read tracking).
module tb_dram_arbiter;
  localparam int W = 128;
  localparam int A = 27;
  localparam int MAXS = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         wr_req = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [A-1:0] wr_adx = '0;
  logic         wr_allowed;
  logic         rd_req = 1'b0;
  logic [A-1:0] rd_adx = '0;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [A-1:0] app_addr;
  logic         app_rdy = 1'b0;
  logic [W-1:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy = 1'b0;
  logic [W-1:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;

  dram_arbiter #(.MEM_IF_WIDTH(W), .ADX_WIDTH(A), .MAX_WR_STREAK(MAXS)) dut (
    .clk(clk), .resetn(resetn),
    .wr_req(wr_req), .wr_data(wr_data), .wr_adx(wr_adx), .wr_allowed(wr_allowed),
    .rd_req(rd_req), .rd_adx(rd_adx), .rd_data(rd_data), .rd_valid(rd_valid),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, bit ok, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // stimulus controls, written only by the main initial block
  int           pk_mode = 0;  // 0 quiet, 1 continuous, 2 random
  int           pk_req = 0, pk_len = 1;
  logic [A-1:0] pk_adx = '0;
  logic [W-1:0] pk_data = '0;
  int           rq_req = 0;
  bit           rq_rand = 0;
  logic [A-1:0] rq_adx = '0;
  int           stall_n = 0, rsp_delay = 1;
  bit           rdy_rand = 0, rsp_rand = 0, rsp_fixed = 0;
  logic [W-1:0] rsp_fixed_data = '0;

  // packer
  initial begin
    int pk_ack = 0, pk_run = 0;
    forever begin
      @(posedge clk); #1;
      if (pk_ack != pk_req) begin pk_ack = pk_req; pk_run = pk_len; end
      if (pk_run > 0) begin
        wr_req = 1'b1; wr_adx = pk_adx; wr_data = pk_data; pk_run--;
      end else begin
        wr_adx  = A'($urandom);
        wr_data = {$urandom, $urandom, $urandom, $urandom};
        wr_req  = (pk_mode == 1) || (pk_mode == 2 && $urandom_range(0, 2) == 0);
      end
    end
  end

  // read requester: holds rd_req/rd_adx until rd_valid
  initial begin
    int rq_ack = 0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) rd_req = 1'b0;
      else if (rd_req) begin
        if (rd_valid) rd_req = 1'b0;
      end else if (rq_ack != rq_req) begin
        rq_ack = rq_req; rd_req = 1'b1; rd_adx = rq_adx;
      end else if (rq_rand && $urandom_range(0, 7) == 0) begin
        rd_req = 1'b1; rd_adx = A'($urandom);
      end
    end
  end

  // controller side: ready generation and delayed read responses
  initial begin
    int  en_run = 0, rsp_cnt = 0;
    bit  rd_hs;
    forever begin
      @(negedge clk);
      rd_hs = app_en && app_rdy && app_cmd == 3'b001;
      @(posedge clk); #1;
      en_run = app_en ? en_run + 1 : 0;
      if (rdy_rand) begin
        app_rdy     = $urandom_range(0, 3) != 0;
        app_wdf_rdy = $urandom_range(0, 3) != 0;
      end else begin
        app_rdy     = en_run > stall_n;
        app_wdf_rdy = 1'b1;
      end
      app_rd_data_valid = 1'b0;
      if (rd_hs) rsp_cnt = rsp_rand ? $urandom_range(1, 6) : rsp_delay;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          app_rd_data_valid = 1'b1;
          app_rd_data = rsp_fixed ? rsp_fixed_data : {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
  end

  // model + per-cycle compare
  typedef struct { logic [A-1:0] adx; logic [W-1:0] data; } wr_t;
  wr_t          wq[$];
  bit           cmd_log[$];      // 0 write, 1 read, in command-accept order
  bit           c_seen = 0, d_seen = 0, rd_out = 0, exp_rv = 0, exp_wa, prev_en = 0;
  logic [W-1:0] exp_rd = '0;
  int           cyc = 0, since_rst = 0, last_cap = 0, last_lat = 0, starve = 0;
  int           en_cycles = 0, wren_cycles = 0, wr_cmds = 0, rd_cmds = 0, rv_cnt = 0;
  int           acc_cnt = 0, done_cnt = 0;
  logic [A-1:0] last_wr_addr = '0, last_rd_addr = '0;
  logic [W-1:0] last_wr_data = '0, last_rd_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      chk("reset_ctl", {app_en, app_wdf_wren, app_wdf_end, rd_valid, wr_allowed} == 5'b0,
          W'({app_en, app_wdf_wren, app_wdf_end, rd_valid, wr_allowed}), '0);
      chk("reset_bus", app_addr == 0 && app_cmd == 0 && app_wdf_data == 0, app_wdf_data, '0);
      wq.delete();
      c_seen = 0; d_seen = 0; rd_out = 0; exp_rv = 0; since_rst = 0; prev_en = 0; starve = 0;
    end else begin
      exp_wa = since_rst > 0 && wq.size() == 0;
      chk("wr_allowed", wr_allowed == exp_wa, W'(wr_allowed), W'(exp_wa));
      chk("wdf_end", app_wdf_end == app_wdf_wren, W'(app_wdf_end), W'(app_wdf_wren));
      if (!app_en) chk("idle_cmd_addr", app_cmd == 0 && app_addr == 0, W'(app_addr), '0);
      if (!app_wdf_wren) chk("idle_wdata", app_wdf_data == 0, app_wdf_data, '0);
      chk("rd_valid", rd_valid == exp_rv, W'(rd_valid), W'(exp_rv));
      if (exp_rv) chk("rd_data", rd_data == exp_rd, rd_data, exp_rd);
      exp_rv = 0;
      if (rd_valid) begin rv_cnt++; last_rd_data = rd_data; end
      if (app_en && !prev_en && app_cmd == 3'b000) begin
        last_lat = cyc - last_cap;
        chk("wr_latency_min", last_lat >= 2, W'(last_lat), W'(2));
      end
      prev_en = app_en;
      if (app_en) en_cycles++;
      if (app_wdf_wren) wren_cycles++;
      if (!rd_req) starve = 0;
      if (app_en && app_rdy) begin
        if (app_cmd == 3'b000) begin
          if (wq.size() == 0) chk("wr_cmd_unexpected", 0, W'(app_addr), '0);
          else begin
            chk("wr_addr", app_addr == wq[0].adx, W'(app_addr), W'(wq[0].adx));
            chk("wr_cmd_once", !c_seen, W'(c_seen), '0);
            c_seen = 1;
          end
          wr_cmds++; last_wr_addr = app_addr; cmd_log.push_back(1'b0);
          if (rd_req && !rd_out) begin
            starve++;
            chk("read_starve", starve <= MAXS + 1, W'(starve), W'(MAXS + 1));
          end
        end else if (app_cmd == 3'b001) begin
          chk("rd_cmd_legal", rd_req && !rd_out, W'({rd_req, rd_out}), W'(2'b10));
          chk("rd_addr", app_addr == rd_adx, W'(app_addr), W'(rd_adx));
          rd_out = 1; rd_cmds++; last_rd_addr = app_addr; cmd_log.push_back(1'b1); starve = 0;
        end else chk("cmd_code", 0, W'(app_cmd), '0);
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        if (wq.size() == 0) chk("wr_data_unexpected", 0, app_wdf_data, '0);
        else begin
          chk("wr_data", app_wdf_data == wq[0].data, app_wdf_data, wq[0].data);
          chk("wr_data_once", !d_seen, W'(d_seen), '0);
          d_seen = 1;
        end
        last_wr_data = app_wdf_data;
      end
      if (c_seen && d_seen) begin
        void'(wq.pop_front()); c_seen = 0; d_seen = 0; done_cnt++;
      end
      if (app_rd_data_valid && rd_out) begin
        exp_rv = 1; exp_rd = app_rd_data; rd_out = 0;
      end
      if (wr_req && exp_wa) begin
        wr_t e;
        e.adx = wr_adx; e.data = wr_data;
        wq.push_back(e); acc_cnt++; last_cap = cyc;
      end
      since_rst++;
    end
  end

  task automatic cyc_wait(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic shot_write(logic [A-1:0] a, logic [W-1:0] d, int len);
    pk_adx = a; pk_data = d; pk_len = len; pk_req++;
  endtask

  initial begin
    int s, s2, s3, i;
    logic [W-1:0] a5;
    a5 = {16{8'hA5}};
    #1 resetn = 1'b0;
    cyc_wait(3);
    chk("reset_wr_allowed", wr_allowed == 1'b0, W'(wr_allowed), '0);
    resetn = 1'b1;
    chk("post_reset_first", wr_allowed == 1'b0, W'(wr_allowed), '0);
    cyc_wait(1);
    chk("post_reset_allowed", wr_allowed == 1'b1, W'(wr_allowed), W'(1));

    // single write, both channels ready
    s = en_cycles; s2 = wren_cycles;
    shot_write(A'(27'h10), a5, 1);
    cyc_wait(8);
    chk("t1_en_cycles", en_cycles - s == 1, W'(en_cycles - s), W'(1));
    chk("t1_wren_cycles", wren_cycles - s2 == 1, W'(wren_cycles - s2), W'(1));
    chk("t1_addr", last_wr_addr == 27'h10, W'(last_wr_addr), W'(27'h10));
    chk("t1_data", last_wr_data == a5, last_wr_data, a5);
    chk("t1_latency", last_lat == 2, W'(last_lat), W'(2));
    chk("t1_allowed_back", wr_allowed == 1'b1, W'(wr_allowed), W'(1));

    // command channel stalls 3 cycles
    stall_n = 3; s = en_cycles; s2 = wren_cycles;
    shot_write(A'(27'h22), {4{32'hCAFE0022}}, 1);
    cyc_wait(12);
    chk("t2_en_cycles", en_cycles - s == 4, W'(en_cycles - s), W'(4));
    chk("t2_wren_cycles", wren_cycles - s2 == 1, W'(wren_cycles - s2), W'(1));
    chk("t2_addr", last_wr_addr == 27'h22, W'(last_wr_addr), W'(27'h22));
    stall_n = 0;

    // read with 5-cycle response
    rsp_delay = 5; rsp_fixed = 1; rsp_fixed_data = W'(16'h1234);
    s = rv_cnt; rq_adx = A'(27'h40); rq_req++;
    for (i = 0; i < 60 && rv_cnt == s; i++) cyc_wait(1);
    chk("t3_rd_done", rv_cnt != s, W'(rv_cnt - s), W'(1));
    cyc_wait(3);
    chk("t3_rv_pulses", rv_cnt - s == 1, W'(rv_cnt - s), W'(1));
    chk("t3_rd_data", last_rd_data == W'(16'h1234), last_rd_data, W'(16'h1234));
    chk("t3_rd_addr", last_rd_addr == 27'h40, W'(last_rd_addr), W'(27'h40));
    rsp_fixed = 0; rsp_delay = 3;

    // streak limit: continuous writes with a read pending
    s = cmd_log.size();
    pk_mode = 1; rq_adx = A'(27'h80); rq_req++;
    for (i = 0; i < 400 && cmd_log.size() < s + 10; i++) cyc_wait(1);
    pk_mode = 0;
    chk("t4_cmds_seen", cmd_log.size() >= s + 10, W'(cmd_log.size() - s), W'(10));
    if (cmd_log.size() >= s + 10)
      for (int k = 0; k < 10; k++)
        chk("t4_sequence", cmd_log[s + k] == (k == 8), W'(cmd_log[s + k]), W'(k == 8));
    cyc_wait(15);

    // wr_req pulses while the holding register is full
    stall_n = 2; s = wr_cmds; s2 = acc_cnt;
    shot_write(A'(27'h33), {4{32'h33333333}}, 3);
    cyc_wait(15);
    chk("t5_wr_cmds", wr_cmds - s == 1, W'(wr_cmds - s), W'(1));
    chk("t5_accepted", acc_cnt - s2 == 1, W'(acc_cnt - s2), W'(1));
    stall_n = 0;

    // reset while a read is outstanding; late response must be dropped
    rsp_delay = 10; s = rd_cmds; s2 = rv_cnt;
    rq_adx = A'(27'h55); rq_req++;
    for (i = 0; i < 40 && rd_cmds == s; i++) cyc_wait(1);
    chk("t6_rd_issued", rd_cmds != s, W'(rd_cmds - s), W'(1));
    cyc_wait(2);
    resetn = 1'b0;
    #1;
    chk("t6_async_ctl", {app_en, app_wdf_wren, rd_valid, wr_allowed} == 4'b0,
        W'({app_en, app_wdf_wren, rd_valid, wr_allowed}), '0);
    chk("t6_async_addr", app_addr == 0 && app_cmd == 0, W'(app_addr), '0);
    cyc_wait(2);
    resetn = 1'b1;
    cyc_wait(15);
    chk("t6_no_rd_valid", rv_cnt == s2, W'(rv_cnt - s2), '0);
    s = en_cycles; s3 = wr_cmds;
    shot_write(A'(27'h66), {4{32'h66666666}}, 1);
    cyc_wait(8);
    chk("t6_idle_write", wr_cmds - s3 == 1 && en_cycles - s == 1, W'(wr_cmds - s3), W'(1));
    chk("t6_idle_latency", last_lat == 2, W'(last_lat), W'(2));
    rsp_delay = 3;

    // randomized traffic
    rdy_rand = 1; rsp_rand = 1; pk_mode = 2; rq_rand = 1;
    cyc_wait(3000);
    pk_mode = 0; rq_rand = 0;
    for (i = 0; i < 500 && (wq.size() != 0 || rd_req); i++) cyc_wait(1);
    chk("drain", wq.size() == 0 && !rd_req, W'(wq.size()), '0);
    chk("accept_vs_done", acc_cnt == done_cnt, W'(done_cnt), W'(acc_cnt));
    rdy_rand = 0;
    cyc_wait(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
